// File: rtl/frame_stream_reader.sv
// rtl/frame_stream_reader.sv - frame buffer read engine streaming pixels over valid/ready
//
// Purpose: once the frame buffer reports a complete frame and a readout is
// requested, the frame RAM is scanned in row-major order. The 1-cycle RAM read
// latency is absorbed by a 2-entry output buffer. Pixels go out with
// end-of-line and end-of-frame markers.
//
// Optional build macro: FRAME_DECIM2_EN enables 2x2 decimation, which reads
// only even columns of even lines.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      request one frame readout (honoured only in IDLE with frame_rdy_i)
//   frame_rdy_i  frame-complete flag from the frame buffer
//   ram_re_o     RAM read enable
//   ram_adr_o    RAM read address
//   ram_dat_i    RAM read data, valid one cycle after ram_re_o
//   px_o         pixel data
//   px_valid_o   px_o valid
//   px_ready_i   consumer accepts px_o
//   px_eol_o     px_o is the last pixel of its line
//   px_last_o    px_o is the last pixel of the frame
//   busy_o       high outside IDLE
//   done_o       one-cycle pulse when the readout completes
module frame_stream_reader #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADR_W = 19,
  parameter int DAT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             frame_rdy_i,
  output logic             ram_re_o,
  output logic [ADR_W-1:0] ram_adr_o,
  input  logic [DAT_W-1:0] ram_dat_i,
  output logic [DAT_W-1:0] px_o,
  output logic             px_valid_o,
  input  logic             px_ready_i,
  output logic             px_eol_o,
  output logic             px_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int EW = DAT_W + 2;  // {last, eol, data}

`ifdef FRAME_DECIM2_EN
  // Step two columns per read; at line wrap also skip the odd line.
  localparam int STEP = 2;
  localparam logic [ADR_W-1:0] A_WRAP = ADR_W'(2 + H_RES);
`else
  localparam int STEP = 1;
  localparam logic [ADR_W-1:0] A_WRAP = ADR_W'(1);
`endif

  localparam logic [XW-1:0]    X_LAST = XW'(H_RES - STEP);
  localparam logic [XW-1:0]    X_STEP = XW'(STEP);
  localparam logic [YW-1:0]    Y_LAST = YW'(V_RES - STEP);
  localparam logic [YW-1:0]    Y_STEP = YW'(STEP);
  localparam logic [ADR_W-1:0] A_STEP = ADR_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [1:0]         occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         pend_q, pend_d;  // {last, eol} of the read in flight
  logic [EW-1:0]      ent0_q, ent0_d;  // buffer head
  logic [EW-1:0]      ent1_q, ent1_d;

  logic               start_go;
  logic               pop;
  logic               at_eol;
  logic               at_last;
  logic [1:0]         fill;
  logic [EW-1:0]      new_ent;

  assign start_go = (state_q == S_IDLE) && start_i && frame_rdy_i;
  assign pop      = px_valid_o && px_ready_i;
  assign at_eol   = (x_q == X_LAST);
  assign at_last  = at_eol && (y_q == Y_LAST);
  assign fill     = occ_q + {1'b0, inflight_q};
  assign new_ent  = {pend_q, ram_dat_i};

  assign px_valid_o = (occ_q != 2'd0);
  assign px_o       = ent0_q[DAT_W-1:0];
  assign px_eol_o   = ent0_q[DAT_W];
  assign px_last_o  = ent0_q[DAT_W+1];

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_go) state_d = S_STREAM;
      S_STREAM: if (ram_re_o && at_last) state_d = S_DRAIN;
      S_DRAIN:  if (pop && px_last_o) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic. A read is allowed while the buffer plus the read in flight
  // hold fewer than two pixels. It is also allowed when they hold exactly two
  // and the head is popped this cycle, because fill never exceeds two.
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    ram_re_o  = 1'b0;
    ram_adr_o = '0;
    if (state_q == S_STREAM) begin
      ram_adr_o = adr_q;
      ram_re_o  = (fill != 2'd2) || pop;
    end
  end

  // Datapath next state: scan counters and output buffer
  always_comb begin
    adr_d      = adr_q;
    x_d        = x_q;
    y_d        = y_q;
    occ_d      = occ_q;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    pend_d     = pend_q;
    inflight_d = ram_re_o;

    if (ram_re_o) pend_d = {at_last, at_eol};

    if (start_go) begin
      adr_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (ram_re_o) begin
      if (at_eol) begin
        x_d   = '0;
        y_d   = y_q + Y_STEP;
        adr_d = adr_q + A_WRAP;
      end else begin
        x_d   = x_q + X_STEP;
        adr_d = adr_q + A_STEP;
      end
    end

    // Data returned by last cycle's read lands in the buffer now.
    unique case (occ_q)
      2'd0: begin
        if (inflight_q) begin
          ent0_d = new_ent;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && inflight_q) begin
          ent0_d = new_ent;
        end else if (inflight_q) begin
          ent1_d = new_ent;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (inflight_q) ent1_d = new_ent;
          else            occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      adr_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      pend_q     <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      adr_q      <= adr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

endmodule
